// File: rtl/spi_xfer_engine_pkg.sv
// Shared definitions for the SPI serial transfer engine: lane modes, FSM states
// and small bit helpers.
package spi_xfer_engine_pkg;

    localparam int SPI_NSS_NUM = 4;

    localparam logic [1:0] SPI_MODE_STD  = 2'b00;
    localparam logic [1:0] SPI_MODE_DUAL = 2'b01;
    localparam logic [1:0] SPI_MODE_QUAD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_WAIT
    } state_e;

    // Index of the final SCK edge of a byte (two edges per bit group).
    function automatic logic [3:0] last_edge(input logic [1:0] mode);
        case (mode)
            SPI_MODE_DUAL: last_edge = 4'd7;
            SPI_MODE_QUAD: last_edge = 4'd3;
            default:       last_edge = 4'd15;
        endcase
    endfunction

    function automatic logic [7:0] bit_rev(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bit_rev[i] = b[7-i];
        end
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK generator: half-period counter, SCK toggle and leading/trailing edge strobes
// that coincide with the clk edge on which SCK changes.
module spi_clkgen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 sck_en_i,
    input  logic                 cpol_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 sck_o,
    output logic                 tick_o,
    output logic                 lead_o,
    output logic                 trail_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sck_q, sck_d;

    always_comb begin
        tick_o  = en_i && !clr_i && (cnt_q == div_i);
        lead_o  = tick_o && sck_en_i && (sck_q == cpol_i);
        trail_o = tick_o && sck_en_i && (sck_q != cpol_i);
        cnt_d   = cnt_q;
        sck_d   = sck_q;
        if (clr_i) begin
            cnt_d = '0;
            sck_d = cpol_i;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
            if (tick_o && sck_en_i) begin
                sck_d = ~sck_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/spi_xfer_engine.sv
// Byte-serial SPI engine: TX/RX handshakes, config latching at byte boundaries,
// standard/dual/quad lane muxing and the IDLE/SETUP/XFER/HOLD/WAIT sequencing.
module spi_xfer_engine
    import spi_xfer_engine_pkg::*;
#(
    parameter int NSS_NUM   = SPI_NSS_NUM,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic                 lsb_i,
    input  logic [1:0]           mode_i,
    input  logic                 dir_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [NSS_NUM-1:0]   nss_sel_i,
    input  logic                 cs_hold_i,
    input  logic                 rx_en_i,
    input  logic                 tx_valid_i,
    input  logic [7:0]           tx_data_i,
    output logic                 tx_ready_o,
    output logic                 rx_valid_o,
    output logic [7:0]           rx_data_o,
    input  logic                 rx_ready_i,
    output logic                 busy_o,
    output logic                 spi_sck_o,
    output logic [NSS_NUM-1:0]   spi_nss_o,
    output logic [3:0]           spi_io_out_o,
    output logic [3:0]           spi_io_en_o,
    input  logic [3:0]           spi_io_in_i
);

    state_e               state_q, state_d;
    logic                 cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic                 dir_q, dir_d, rx_en_q, rx_en_d;
    logic [1:0]           mode_q, mode_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [NSS_NUM-1:0]   nss_sel_q, nss_sel_d;
    logic [7:0]           tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [3:0]           edge_q, edge_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 run_q;

    logic is_idle, is_wait, tx_hs;
    logic cg_en, cg_clr, cg_sck_en, cg_cpol, tick, lead, trail, sample, shift;

    assign is_idle    = (state_q == ST_IDLE);
    assign is_wait    = (state_q == ST_WAIT);
    assign tx_ready_o = run_q && (is_idle || is_wait);
    assign tx_hs      = tx_valid_i && tx_ready_o;
    assign busy_o     = !is_idle;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;

    assign cg_en     = (state_q == ST_SETUP) || (state_q == ST_XFER) ||
                       ((state_q == ST_HOLD) && !rx_valid_q);
    assign cg_clr    = is_idle || is_wait;
    assign cg_sck_en = (state_q == ST_XFER);
    assign cg_cpol   = is_idle ? cpol_i : cpol_q;

    spi_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (cg_en),
        .clr_i    (cg_clr),
        .sck_en_i (cg_sck_en),
        .cpol_i   (cg_cpol),
        .div_i    (div_q),
        .sck_o    (spi_sck_o),
        .tick_o   (tick),
        .lead_o   (lead),
        .trail_o  (trail)
    );

    // With CPHA=1 the first group is already on the pads, so the first leading edge must not shift.
    assign sample = cpha_q ? trail : lead;
    assign shift  = cpha_q ? (lead && (edge_q != 4'd0)) : trail;

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        div_d      = div_q;
        nss_sel_d  = nss_sel_q;
        rx_en_d    = rx_en_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        edge_d     = edge_q;
        rx_valid_d = rx_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_hs) begin
                    cpol_d    = cpol_i;
                    cpha_d    = cpha_i;
                    lsb_d     = lsb_i;
                    mode_d    = mode_i;
                    dir_d     = dir_i;
                    div_d     = div_i;
                    nss_sel_d = nss_sel_i;
                    rx_en_d   = rx_en_i;
                    tx_sh_d   = lsb_i ? bit_rev(tx_data_i) : tx_data_i;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    edge_d  = 4'd0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (sample) begin
                    case (mode_q)
                        SPI_MODE_DUAL: rx_sh_d = {rx_sh_q[5:0], spi_io_in_i[1:0]};
                        SPI_MODE_QUAD: rx_sh_d = {rx_sh_q[3:0], spi_io_in_i};
                        default:       rx_sh_d = {rx_sh_q[6:0], spi_io_in_i[1]};
                    endcase
                end
                if (shift) begin
                    case (mode_q)
                        SPI_MODE_DUAL: tx_sh_d = {tx_sh_q[5:0], 2'b00};
                        SPI_MODE_QUAD: tx_sh_d = {tx_sh_q[3:0], 4'b0000};
                        default:       tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    endcase
                end
                if (lead || trail) begin
                    edge_d = edge_q + 1'b1;
                    if (edge_q == last_edge(mode_q)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (rx_valid_q) begin
                    if (rx_ready_i) begin
                        rx_valid_d = 1'b0;
                        state_d    = cs_hold_i ? ST_WAIT : ST_IDLE;
                    end
                end else if (tick) begin
                    if (rx_en_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = lsb_q ? bit_rev(rx_sh_q) : rx_sh_q;
                    end else begin
                        state_d = cs_hold_i ? ST_WAIT : ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (tx_hs) begin
                    tx_sh_d = lsb_q ? bit_rev(tx_data_i) : tx_data_i;
                    edge_d  = 4'd0;
                    state_d = ST_XFER;
                end else if (!cs_hold_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pads: unused dual/standard lanes carry WP#/HOLD# driven inactive high.
    always_comb begin
        spi_nss_o    = is_idle ? '1 : ~nss_sel_q;
        spi_io_out_o = 4'h0;
        spi_io_en_o  = 4'hF;
        if (!is_idle) begin
            case (mode_q)
                SPI_MODE_DUAL: begin
                    spi_io_out_o = {2'b11, tx_sh_q[7:6]};
                    spi_io_en_o  = {2'b00, dir_q, dir_q};
                end
                SPI_MODE_QUAD: begin
                    spi_io_out_o = tx_sh_q[7:4];
                    spi_io_en_o  = {4{dir_q}};
                end
                default: begin
                    spi_io_out_o = {2'b11, 1'b0, tx_sh_q[7]};
                    spi_io_en_o  = 4'b0010;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            mode_q     <= SPI_MODE_STD;
            dir_q      <= 1'b0;
            div_q      <= '0;
            nss_sel_q  <= '0;
            rx_en_q    <= 1'b0;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            edge_q     <= 4'd0;
            rx_valid_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            div_q      <= div_d;
            nss_sel_q  <= nss_sel_d;
            rx_en_q    <= rx_en_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            edge_q     <= edge_d;
            rx_valid_q <= rx_valid_d;
            run_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine: reset, std/mode3/quad bytes, cs_hold chain,
// RX backpressure and reset mid-byte, with hand-computed expectations.
module tb_spi_xfer_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpol = 1'b1, cpha = 1'b0, lsb = 1'b0, dir = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] div = 16'd1;
    logic [3:0]  nss_sel = 4'b0001;
    logic        cs_hold = 1'b0, rx_en = 1'b1;
    logic        tx_valid = 1'b0, rx_ready = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready, rx_valid, busy, sck;
    logic [7:0]  rx_data;
    logic [3:0]  nss, io_out, io_en, io_in;

    int          checks = 0, errors = 0;
    int          in_sel = 0;
    logic [3:0]  nib = 4'hD;
    logic        quad_model = 1'b0, watch_en = 1'b0;
    logic [7:0]  mosi_cap = 8'h00;
    int          toggles = 0, leads = 0, en_bad = 0, nss_rise = 0, lat = 0, bp_bad = 0;
    logic        prev_sck = 1'b0;
    logic [3:0]  prev_nss = 4'hF;

    always #5 clk = ~clk;

    assign io_in = (in_sel == 0) ? {2'b00, io_out[0], 1'b0} :
                   (in_sel == 1) ? 4'hF : nib;

    spi_xfer_engine dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cpol_i       (cpol),
        .cpha_i       (cpha),
        .lsb_i        (lsb),
        .mode_i       (mode),
        .dir_i        (dir),
        .div_i        (div),
        .nss_sel_i    (nss_sel),
        .cs_hold_i    (cs_hold),
        .rx_en_i      (rx_en),
        .tx_valid_i   (tx_valid),
        .tx_data_i    (tx_data),
        .tx_ready_o   (tx_ready),
        .rx_valid_o   (rx_valid),
        .rx_data_o    (rx_data),
        .rx_ready_i   (rx_ready),
        .busy_o       (busy),
        .spi_sck_o    (sck),
        .spi_nss_o    (nss),
        .spi_io_out_o (io_out),
        .spi_io_en_o  (io_en),
        .spi_io_in_i  (io_in)
    );

    // Pad monitor: SCK edges, MOSI capture on the sampling edge, quad slave model.
    always @(posedge clk) begin
        #1;
        if (sck != prev_sck) begin
            toggles++;
            if (sck != cpol) leads++;
            if ((sck != cpol) != cpha) mosi_cap = {mosi_cap[6:0], io_out[0]};
            if ((sck == cpol) && quad_model) nib = 4'h2;
        end
        if (watch_en && busy && (io_en != 4'hF)) en_bad++;
        if ((nss == 4'hF) && (prev_nss != 4'hF)) nss_rise++;
        prev_sck = sck;
        prev_nss = nss;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end else begin
            $display("ok   %s act=%0h", tag, act);
        end
    endtask

    task automatic tx_push(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("tx_ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_rx(output int l);
        l = 0;
        while (!rx_valid && l < 4000) begin
            @(posedge clk);
            #1 l++;
        end
    endtask

    task automatic rx_pop();
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    initial begin
        // Reset held 40 clk with CPOL=1 requested: SCK must still read 0.
        repeat (40) @(posedge clk);
        #1;
        chk("rst_nss", nss, 4'hF);
        chk("rst_io_en", io_en, 4'hF);
        chk("rst_io_out", io_out, 4'h0);
        chk("rst_sck", sck, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_tx_ready", tx_ready, 1'b1);
        cpol = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Standard mode 0, div=1, loopback; div/mode changed mid-byte must not matter.
        in_sel = 0; mosi_cap = 8'h00; toggles = 0;
        tx_push(8'hA5);
        div = 16'd5; mode = 2'b10;
        wait_rx(lat);
        chk("std_latency", 32'(lat), 32'd36);
        chk("std_rx", rx_data, 8'hA5);
        chk("std_mosi", mosi_cap, 8'hA5);
        chk("std_sck_edges", 32'(toggles), 32'd16);
        rx_pop();
        div = 16'd1; mode = 2'b00;

        // Mode 3, LSB first, MISO tied high.
        cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; in_sel = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("m3_sck_idle", sck, 1'b1);
        mosi_cap = 8'h00; toggles = 0;
        tx_push(8'h3C);
        wait_rx(lat);
        chk("m3_rx", rx_data, 8'hFF);
        chk("m3_mosi", mosi_cap, 8'h3C);
        chk("m3_sck_edges", 32'(toggles), 32'd16);
        rx_pop();
        mosi_cap = 8'h00;
        tx_push(8'h01);
        wait_rx(lat);
        chk("m3_lsb_mosi", mosi_cap, 8'h80);
        chk("m3_lsb_rx", rx_data, 8'hFF);
        rx_pop();
        repeat (2) @(posedge clk);
        #1;
        chk("m3_sck_end", sck, 1'b1);

        // Quad read, div=2: slave drives 0xD then 0x2.
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; mode = 2'b10; dir = 1'b1; div = 16'd2;
        in_sel = 2; nib = 4'hD;
        repeat (3) @(posedge clk);
        #1;
        leads = 0; en_bad = 0; quad_model = 1'b1; watch_en = 1'b1;
        tx_push(8'h00);
        wait_rx(lat);
        chk("quad_latency", 32'(lat), 32'd18);
        chk("quad_rx", rx_data, 8'hD2);
        chk("quad_sck_cycles", 32'(leads), 32'd2);
        chk("quad_io_en_released", 32'(en_bad), 32'd0);
        rx_pop();
        quad_model = 1'b0; watch_en = 1'b0;

        // cs_hold chain: div=0, second byte skips SETUP (17 half-periods instead of 18).
        mode = 2'b00; dir = 1'b0; div = 16'd0; in_sel = 0; nss_sel = 4'b0100; cs_hold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nss_rise = 0;
        tx_push(8'h5A);
        wait_rx(lat);
        chk("chain1_latency", 32'(lat), 32'd18);
        chk("chain1_rx", rx_data, 8'h5A);
        rx_pop();
        @(posedge clk);
        #1;
        chk("chain_wait_nss", nss, 4'hB);
        chk("chain_wait_busy", busy, 1'b1);
        tx_push(8'hC3);
        wait_rx(lat);
        chk("chain2_latency", 32'(lat), 32'd17);
        chk("chain2_rx", rx_data, 8'hC3);
        cs_hold = 1'b0;
        rx_pop();
        repeat (3) @(posedge clk);
        #1;
        chk("chain_end_nss", nss, 4'hF);
        chk("chain_nss_rises", 32'(nss_rise), 32'd1);
        chk("chain_end_busy", busy, 1'b0);

        // RX backpressure: 50 clk without rx_ready while another byte is offered.
        div = 16'd1; nss_sel = 4'b0001;
        tx_push(8'h96);
        wait_rx(lat);
        chk("bp_latency", 32'(lat), 32'd36);
        tx_data = 8'h11; tx_valid = 1'b1; toggles = 0; bp_bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (!rx_valid || rx_data != 8'h96 || tx_ready) bp_bad++;
        end
        tx_valid = 1'b0;
        chk("bp_stable", 32'(bp_bad), 32'd0);
        chk("bp_no_sck", 32'(toggles), 32'd0);
        chk("bp_busy", busy, 1'b1);
        rx_pop();

        // Reset mid-byte: SCK is high after the first edge, outputs drop at once.
        tx_push(8'h11);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_sck_high", sck, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_nss", nss, 4'hF);
        chk("mid_rst_sck", sck, 1'b0);
        chk("mid_rst_io_en", io_en, 4'hF);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_tx_ready", tx_ready, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_rst_no_rx", rx_valid, 1'b0);
        chk("mid_rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
